// File: rtl/sdram_port_arb.sv
`default_nettype none
// sdram_port_arb: three-client arbiter/sequencer for the MiST SDRAM port1, with an ack watchdog.
// Define SDRAM_ARB_RR_EN for round-robin arbitration; otherwise fixed priority c0 > c1 > c2.
module sdram_port_arb #(
   parameter logic [7:0] ACK_TIMEOUT = 8'd200
) (
   input  logic        clk_96,
   input  logic        init_n,
   input  logic        ready,

   input  logic        c0_req,
   input  logic        c0_we,
   input  logic [22:0] c0_addr,
   input  logic [15:0] c0_din,
   input  logic [1:0]  c0_ds,
   output logic [15:0] c0_dout,
   output logic        c0_ack,
   output logic        c0_err,

   input  logic        c1_req,
   input  logic        c1_we,
   input  logic [22:0] c1_addr,
   input  logic [15:0] c1_din,
   input  logic [1:0]  c1_ds,
   output logic [15:0] c1_dout,
   output logic        c1_ack,
   output logic        c1_err,

   input  logic        c2_req,
   input  logic        c2_we,
   input  logic [22:0] c2_addr,
   input  logic [15:0] c2_din,
   input  logic [1:0]  c2_ds,
   output logic [15:0] c2_dout,
   output logic        c2_ack,
   output logic        c2_err,

   output logic        port1_req,
   output logic        port1_we,
   output logic [22:0] port1_addr,
   output logic [15:0] port1_din,
   output logic [1:0]  port1_ds,
   input  logic [15:0] port1_dout,
   input  logic        port1_ack,

   output logic        busy,
   output logic [1:0]  grant
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic              do_grant;
   logic              do_done;
   logic              do_abort;

   logic [2:0]        req_v;
   logic [2:0]        we_v;
   logic [2:0][22:0]  addr_v;
   logic [2:0][15:0]  din_v;
   logic [2:0][1:0]   ds_v;

   logic              win_valid;
   logic [1:0]        win_idx;

   logic [7:0]        wdog;
   logic [2:0]        ack_r;
   logic [2:0]        err_r;
   logic [2:0][15:0]  dout_r;

   assign req_v  = {c2_req, c1_req, c0_req};
   assign we_v   = {c2_we, c1_we, c0_we};
   assign addr_v = {c2_addr, c1_addr, c0_addr};
   assign din_v  = {c2_din, c1_din, c0_din};
   assign ds_v   = {c2_ds, c1_ds, c0_ds};

`ifdef SDRAM_ARB_RR_EN
   logic [1:0] rr_ptr;
   logic [1:0] ord0;
   logic [1:0] ord1;
   logic [1:0] ord2;

   function automatic logic [1:0] next_idx(input logic [1:0] i);
      return (i == 2'd2) ? 2'd0 : i + 2'd1;
   endfunction

   // Search starts one past the last winner and wraps modulo 3.
   always_comb begin
      ord0      = next_idx(rr_ptr);
      ord1      = next_idx(ord0);
      ord2      = next_idx(ord1);
      win_valid = |req_v;
      if (req_v[ord0])
         win_idx = ord0;
      else if (req_v[ord1])
         win_idx = ord1;
      else
         win_idx = ord2;
   end

   always_ff @(posedge clk_96 or negedge init_n) begin
      if (!init_n)
         rr_ptr <= 2'd2;
      else if (do_grant)
         rr_ptr <= win_idx;
   end
`else
   always_comb begin
      win_valid = |req_v;
      if (req_v[0])
         win_idx = 2'd0;
      else if (req_v[1])
         win_idx = 2'd1;
      else
         win_idx = 2'd2;
   end
`endif

   always_ff @(posedge clk_96 or negedge init_n) begin
      if (!init_n)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   // A controller ack on the same edge as watchdog expiry takes precedence.
   always_comb begin
      state_nxt = state;
      do_grant  = 1'b0;
      do_done   = 1'b0;
      do_abort  = 1'b0;
      case (state)
         S_IDLE: begin
            if (ready && win_valid) begin
               do_grant  = 1'b1;
               state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (port1_ack) begin
               do_done   = 1'b1;
               state_nxt = S_DONE;
            end else if (wdog == 8'd0) begin
               do_abort  = 1'b1;
               state_nxt = S_DONE;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_96 or negedge init_n) begin
      if (!init_n) begin
         port1_req  <= 1'b0;
         port1_we   <= 1'b0;
         port1_addr <= 23'd0;
         port1_din  <= 16'd0;
         port1_ds   <= 2'd0;
         grant      <= 2'd3;
         wdog       <= 8'd0;
         ack_r      <= 3'b000;
         err_r      <= 3'b000;
         dout_r     <= '0;
      end else begin
         ack_r <= 3'b000;
         err_r <= 3'b000;

         if (do_grant) begin
            port1_req  <= 1'b1;
            port1_we   <= we_v[win_idx];
            port1_addr <= addr_v[win_idx];
            port1_din  <= din_v[win_idx];
            port1_ds   <= ds_v[win_idx];
            grant      <= win_idx;
            wdog       <= ACK_TIMEOUT;
         end

         if (state == S_ISSUE && !do_done && !do_abort)
            wdog <= wdog - 8'd1;

         if (do_done) begin
            port1_req <= 1'b0;
            ack_r     <= 3'b001 << grant;
            for (int i = 0; i < 3; i++) begin
               if (!port1_we && grant == i[1:0])
                  dout_r[i] <= port1_dout;
            end
         end

         if (do_abort) begin
            port1_req <= 1'b0;
            ack_r     <= 3'b001 << grant;
            err_r     <= 3'b001 << grant;
         end
      end
   end

   assign busy    = (state != S_IDLE);

   assign c0_ack  = ack_r[0];
   assign c1_ack  = ack_r[1];
   assign c2_ack  = ack_r[2];
   assign c0_err  = err_r[0];
   assign c1_err  = err_r[1];
   assign c2_err  = err_r[2];
   assign c0_dout = dout_r[0];
   assign c1_dout = dout_r[1];
   assign c2_dout = dout_r[2];

endmodule
`default_nettype wire

// File: tb/tb_sdram_port_arb.sv
`default_nettype none
// tb_sdram_port_arb: directed and randomized checks of sdram_port_arb against a transaction-level model.
module tb_sdram_port_arb;

   localparam logic [7:0] TO = 8'd16;

   logic        clk_96 = 1'b0;
   logic        init_n = 1'b0;
   logic        ready  = 1'b0;
   logic [2:0]  req    = 3'b000;
   logic [2:0]  we     = 3'b000;
   logic [22:0] addr [3];
   logic [15:0] din  [3];
   logic [1:0]  ds   [3];
   logic [15:0] dout [3];
   logic [2:0]  ack;
   logic [2:0]  err;

   logic        port1_req;
   logic        port1_we;
   logic [22:0] port1_addr;
   logic [15:0] port1_din;
   logic [1:0]  port1_ds;
   logic [15:0] port1_dout = 16'd0;
   logic        port1_ack  = 1'b0;
   logic        busy;
   logic [1:0]  grant;

   int n_cmp = 0;
   int n_bad = 0;

   // transaction-level model: pending requests, their captured fields, last winner, client data
   bit   [2:0]  pend = 3'b000;
   logic        m_we   [3];
   logic [22:0] m_addr [3];
   logic [15:0] m_din  [3];
   logic [1:0]  m_ds   [3];
   logic [15:0] exp_dout [3];
   int          last = 2;

   always #5 clk_96 = ~clk_96;

   sdram_port_arb #(.ACK_TIMEOUT(TO)) dut (
      .clk_96(clk_96), .init_n(init_n), .ready(ready),
      .c0_req(req[0]), .c0_we(we[0]), .c0_addr(addr[0]), .c0_din(din[0]), .c0_ds(ds[0]),
      .c0_dout(dout[0]), .c0_ack(ack[0]), .c0_err(err[0]),
      .c1_req(req[1]), .c1_we(we[1]), .c1_addr(addr[1]), .c1_din(din[1]), .c1_ds(ds[1]),
      .c1_dout(dout[1]), .c1_ack(ack[1]), .c1_err(err[1]),
      .c2_req(req[2]), .c2_we(we[2]), .c2_addr(addr[2]), .c2_din(din[2]), .c2_ds(ds[2]),
      .c2_dout(dout[2]), .c2_ack(ack[2]), .c2_err(err[2]),
      .port1_req(port1_req), .port1_we(port1_we), .port1_addr(port1_addr),
      .port1_din(port1_din), .port1_ds(port1_ds), .port1_dout(port1_dout),
      .port1_ack(port1_ack), .busy(busy), .grant(grant)
   );

   function automatic int pick(bit [2:0] p);
`ifdef SDRAM_ARB_RR_EN
      for (int k = 1; k <= 3; k++)
         if (p[(last + k) % 3]) return (last + k) % 3;
`else
      for (int k = 0; k < 3; k++)
         if (p[k]) return k;
`endif
      return -1;
   endfunction

   task automatic raise(input int c, input logic w, input logic [22:0] a,
                        input logic [15:0] d, input logic [1:0] s);
      req[c] = 1'b1;  we[c] = w;  addr[c] = a;  din[c] = d;  ds[c] = s;
      pend[c] = 1'b1; m_we[c] = w; m_addr[c] = a; m_din[c] = d; m_ds[c] = s;
   endtask

   task automatic drop(input int c);
      req[c]  = 1'b0;
      pend[c] = 1'b0;
   endtask

   task automatic wait_req(output int cycles);
      cycles = 0;
      while (port1_req !== 1'b1 && cycles < 40) begin
         @(negedge clk_96);
         cycles++;
      end
   endtask

   task automatic reset_dut();
      @(negedge clk_96);
      init_n = 1'b0;
      req = 3'b000;
      pend = 3'b000;
      port1_ack = 1'b0;
      @(negedge clk_96);
      init_n = 1'b1;
      last = 2;
      for (int i = 0; i < 3; i++) exp_dout[i] = 16'd0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk_96);
      n_cmp++; if (port1_req !== 1'b0) begin n_bad++; $display("FAIL reset port1_req: got %b want 0", port1_req); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset busy: got %b want 0", busy); end
      n_cmp++; if (grant !== 2'd3) begin n_bad++; $display("FAIL reset grant: got %0d want 3", grant); end
      n_cmp++; if (ack !== 3'b000 || err !== 3'b000) begin n_bad++; $display("FAIL reset ack/err: got %b/%b want 000/000", ack, err); end
      n_cmp++; if ({port1_we, port1_addr, port1_din, port1_ds} !== 42'd0) begin n_bad++; $display("FAIL reset port1 fields: got %b %h %h %b want zeros", port1_we, port1_addr, port1_din, port1_ds); end
      init_n = 1'b1;
      @(negedge clk_96);
      for (int i = 0; i < 3; i++) begin
         n_cmp++; if (dout[i] !== 16'd0) begin n_bad++; $display("FAIL reset dout%0d: got %h want 0000", i, dout[i]); end
      end
      n_cmp++; if (grant !== 2'd3) begin n_bad++; $display("FAIL reset grant after release: got %0d want 3", grant); end
   endtask

   task automatic test_single_read();
      int cy;
      ready = 1'b1;
      raise(1, 1'b0, 23'h000123, 16'h0000, 2'b11);
      wait_req(cy);
      n_cmp++; if (cy >= 40) begin n_bad++; $display("FAIL read wait port1_req: got timeout want grant"); end
      n_cmp++; if (port1_addr !== 23'h000123 || port1_we !== 1'b0) begin n_bad++; $display("FAIL read port1 addr/we: got %h/%b want 000123/0", port1_addr, port1_we); end
      n_cmp++; if (grant !== 2'd1 || busy !== 1'b1) begin n_bad++; $display("FAIL read grant/busy: got %0d/%b want 1/1", grant, busy); end
      last = 1;
      repeat (3) @(negedge clk_96);
      n_cmp++; if (port1_req !== 1'b1 || ack !== 3'b000) begin n_bad++; $display("FAIL read hold: got req %b ack %b want 1 000", port1_req, ack); end
      port1_ack = 1'b1; port1_dout = 16'hBEEF;
      @(negedge clk_96);
      port1_ack = 1'b0; port1_dout = 16'h0F0F;
      exp_dout[1] = 16'hBEEF;
      n_cmp++; if (ack !== 3'b010 || err !== 3'b000) begin n_bad++; $display("FAIL read ack/err: got %b/%b want 010/000", ack, err); end
      n_cmp++; if (dout[1] !== 16'hBEEF) begin n_bad++; $display("FAIL read c1_dout: got %h want beef", dout[1]); end
      n_cmp++; if (port1_req !== 1'b0) begin n_bad++; $display("FAIL read port1_req drop: got %b want 0", port1_req); end
      drop(1);
      @(negedge clk_96);
      n_cmp++; if (ack !== 3'b000 || busy !== 1'b0) begin n_bad++; $display("FAIL read after done: got ack %b busy %b want 000 0", ack, busy); end
   endtask

   task automatic test_write();
      int cy;
      raise(0, 1'b1, 23'h7ABCDE, 16'h55AA, 2'b01);
      wait_req(cy);
      n_cmp++; if (cy >= 40) begin n_bad++; $display("FAIL write wait port1_req: got timeout want grant"); end
      n_cmp++; if (port1_din !== 16'h55AA || port1_ds !== 2'b01 || port1_we !== 1'b1) begin n_bad++; $display("FAIL write port1 din/ds/we: got %h/%b/%b want 55aa/01/1", port1_din, port1_ds, port1_we); end
      last = 0;
      @(negedge clk_96);
      port1_ack = 1'b1; port1_dout = 16'h1234;
      @(negedge clk_96);
      port1_ack = 1'b0;
      n_cmp++; if (ack !== 3'b001 || err !== 3'b000) begin n_bad++; $display("FAIL write ack/err: got %b/%b want 001/000", ack, err); end
      n_cmp++; if (dout[0] !== exp_dout[0]) begin n_bad++; $display("FAIL write c0_dout unchanged: got %h want %h", dout[0], exp_dout[0]); end
      drop(0);
      @(negedge clk_96);
   endtask

   task automatic test_arbitration();
      int cy, w;
      logic [2:0] e_ack;
      reset_dut();
      ready = 1'b1;
      raise(0, 1'b0, 23'h000010, 16'd0, 2'b11);
      raise(1, 1'b0, 23'h000020, 16'd0, 2'b11);
      raise(2, 1'b0, 23'h000030, 16'd0, 2'b11);
      for (int n = 0; n < 6; n++) begin
         wait_req(cy);
         w = pick(pend);
         n_cmp++; if (cy >= 40 || grant !== w[1:0]) begin n_bad++; $display("FAIL arb grant #%0d: got %0d want %0d", n, grant, w); end
         n_cmp++; if (port1_addr !== m_addr[w]) begin n_bad++; $display("FAIL arb addr #%0d: got %h want %h", n, port1_addr, m_addr[w]); end
         last = w;
         repeat ($urandom_range(0, 3)) @(negedge clk_96);
         port1_ack = 1'b1; port1_dout = 16'hA000 + 16'(n);
         @(negedge clk_96);
         port1_ack = 1'b0;
         exp_dout[w] = 16'hA000 + 16'(n);
         e_ack = 3'b001 << w;
         n_cmp++; if (ack !== e_ack || err !== 3'b000) begin n_bad++; $display("FAIL arb ack #%0d: got %b/%b want %b/000", n, ack, err, e_ack); end
         if (n == 5) begin
            drop(0); drop(1); drop(2);
         end
      end
      @(negedge clk_96);
   endtask

   task automatic test_timeout();
      int cy, cnt;
      raise(2, 1'b0, 23'h001000, 16'd0, 2'b11);
      wait_req(cy);
      n_cmp++; if (cy >= 40 || grant !== 2'd2) begin n_bad++; $display("FAIL timeout grant: got %0d want 2", grant); end
      last = 2;
      cnt = 0;
      while (ack === 3'b000 && cnt < 40) begin
         @(negedge clk_96);
         cnt++;
      end
      n_cmp++; if (cnt != 17) begin n_bad++; $display("FAIL timeout latency: got %0d want 17", cnt); end
      n_cmp++; if (ack !== 3'b100 || err !== 3'b100) begin n_bad++; $display("FAIL timeout ack/err: got %b/%b want 100/100", ack, err); end
      n_cmp++; if (port1_req !== 1'b0 || dout[2] !== exp_dout[2]) begin n_bad++; $display("FAIL timeout req/dout: got %b/%h want 0/%h", port1_req, dout[2], exp_dout[2]); end
      drop(2);
      raise(1, 1'b0, 23'h002000, 16'd0, 2'b11);
      wait_req(cy);
      n_cmp++; if (cy >= 40 || grant !== 2'd1) begin n_bad++; $display("FAIL timeout next grant: got %0d want 1", grant); end
      last = 1;
      port1_ack = 1'b1; port1_dout = 16'hC0DE;
      @(negedge clk_96);
      port1_ack = 1'b0;
      exp_dout[1] = 16'hC0DE;
      n_cmp++; if (ack !== 3'b010 || err !== 3'b000 || dout[1] !== 16'hC0DE) begin n_bad++; $display("FAIL timeout next xfer: got %b/%b/%h want 010/000/c0de", ack, err, dout[1]); end
      drop(1);
      @(negedge clk_96);
   endtask

   task automatic test_ready();
      ready = 1'b0;
      raise(1, 1'b0, 23'h003000, 16'd0, 2'b11);
      repeat (5) @(negedge clk_96);
      n_cmp++; if (port1_req !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL ready low: got req %b busy %b want 0 0", port1_req, busy); end
      ready = 1'b1;
      @(negedge clk_96);
      n_cmp++; if (port1_req !== 1'b1 || grant !== 2'd1) begin n_bad++; $display("FAIL ready rise: got req %b grant %0d want 1 1", port1_req, grant); end
      last = 1;
      ready = 1'b0;
      repeat (3) @(negedge clk_96);
      port1_ack = 1'b1; port1_dout = 16'h7777;
      @(negedge clk_96);
      port1_ack = 1'b0;
      exp_dout[1] = 16'h7777;
      n_cmp++; if (ack !== 3'b010 || err !== 3'b000) begin n_bad++; $display("FAIL ready drop in issue: got %b/%b want 010/000", ack, err); end
      drop(1);
      ready = 1'b1;
      @(negedge clk_96);
   endtask

   task automatic test_reset_mid();
      int cy, w;
      logic [2:0] e_ack;
      raise(0, 1'b0, 23'h004000, 16'd0, 2'b11);
      wait_req(cy);
      @(negedge clk_96);
      #2 init_n = 1'b0;
      #1;
      n_cmp++; if (port1_req !== 1'b0 || busy !== 1'b0 || grant !== 2'd3) begin n_bad++; $display("FAIL midreset: got req %b busy %b grant %0d want 0 0 3", port1_req, busy, grant); end
      n_cmp++; if (ack !== 3'b000 || dout[1] !== 16'd0) begin n_bad++; $display("FAIL midreset ack/dout: got %b/%h want 000/0000", ack, dout[1]); end
      drop(0);
      @(negedge clk_96);
      init_n = 1'b1;
      last = 2;
      for (int i = 0; i < 3; i++) exp_dout[i] = 16'd0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_96);
         n_cmp++; if (ack !== 3'b000 || port1_req !== 1'b0) begin n_bad++; $display("FAIL post-reset quiet: got ack %b req %b want 000 0", ack, port1_req); end
      end
      raise(0, 1'b0, 23'h005000, 16'd0, 2'b11);
      raise(2, 1'b0, 23'h006000, 16'd0, 2'b11);
      for (int n = 0; n < 2; n++) begin
         wait_req(cy);
         w = pick(pend);
         n_cmp++; if (cy >= 40 || grant !== w[1:0]) begin n_bad++; $display("FAIL post-reset grant #%0d: got %0d want %0d", n, grant, w); end
         last = w;
         port1_ack = 1'b1; port1_dout = 16'h5150 + 16'(n);
         @(negedge clk_96);
         port1_ack = 1'b0;
         exp_dout[w] = 16'h5150 + 16'(n);
         e_ack = 3'b001 << w;
         n_cmp++; if (ack !== e_ack) begin n_bad++; $display("FAIL post-reset ack #%0d: got %b want %b", n, ack, e_ack); end
         drop(w);
      end
      @(negedge clk_96);
   endtask

   task automatic test_random();
      int cy, w, mode, cnt;
      logic [31:0] r;
      logic [15:0] rd;
      logic [2:0]  e_ack;
      for (int t = 0; t < 60; t++) begin
         for (int c = 0; c < 3; c++) begin
            if (!pend[c] && $urandom_range(0, 2) != 0) begin
               r = $urandom;
               raise(c, r[31], r[22:0], r[15:0] ^ 16'h3C3C, r[29:28]);
            end
         end
         if (pend == 3'b000) begin
            r = $urandom;
            raise(int'(r[1:0] % 3), r[31], r[24:2], r[17:2], r[26:25]);
         end
         wait_req(cy);
         w = pick(pend);
         n_cmp++; if (cy >= 40 || grant !== w[1:0]) begin n_bad++; $display("FAIL rnd grant t%0d: got %0d want %0d", t, grant, w); end
         n_cmp++;
         if (port1_we !== m_we[w] || port1_addr !== m_addr[w] || port1_din !== m_din[w] || port1_ds !== m_ds[w]) begin
            n_bad++;
            $display("FAIL rnd port1 t%0d: got %b %h %h %b want %b %h %h %b", t, port1_we, port1_addr, port1_din, port1_ds, m_we[w], m_addr[w], m_din[w], m_ds[w]);
         end
         last = w;
         addr[w] = ~addr[w];
         din[w]  = ~din[w];
         we[w]   = ~we[w];
         mode = $urandom_range(0, 9);
         e_ack = 3'b001 << w;
         if (mode <= 7) begin
            repeat ((mode == 7) ? 16 : mode) @(negedge clk_96);
            n_cmp++; if (port1_req !== 1'b1 || port1_addr !== m_addr[w] || ack !== 3'b000) begin n_bad++; $display("FAIL rnd hold t%0d: got req %b addr %h ack %b want 1 %h 000", t, port1_req, port1_addr, ack, m_addr[w]); end
            rd = 16'($urandom);
            port1_ack = 1'b1; port1_dout = rd;
            @(negedge clk_96);
            port1_ack = 1'b0;
            if (!m_we[w]) exp_dout[w] = rd;
            n_cmp++; if (ack !== e_ack || err !== 3'b000) begin n_bad++; $display("FAIL rnd ack t%0d: got %b/%b want %b/000", t, ack, err, e_ack); end
         end else begin
            cnt = 0;
            while (ack === 3'b000 && cnt < 40) begin
               @(negedge clk_96);
               cnt++;
            end
            n_cmp++; if (cnt != 17 || ack !== e_ack || err !== e_ack) begin n_bad++; $display("FAIL rnd timeout t%0d: got %0d cycles %b/%b want 17 %b/%b", t, cnt, ack, err, e_ack, e_ack); end
         end
         n_cmp++; if (port1_req !== 1'b0) begin n_bad++; $display("FAIL rnd req drop t%0d: got %b want 0", t, port1_req); end
         for (int i = 0; i < 3; i++) begin
            n_cmp++; if (dout[i] !== exp_dout[i]) begin n_bad++; $display("FAIL rnd dout%0d t%0d: got %h want %h", i, t, dout[i], exp_dout[i]); end
         end
         drop(w);
      end
      @(negedge clk_96);
   endtask

   initial begin
      #500000;
      $display("FAIL global time limit: got no finish want finish");
      $fatal(1, "bench time limit");
   end

   initial begin
      for (int i = 0; i < 3; i++) begin
         addr[i] = 23'd0; din[i] = 16'd0; ds[i] = 2'd0;
         m_we[i] = 1'b0; m_addr[i] = 23'd0; m_din[i] = 16'd0; m_ds[i] = 2'd0;
         exp_dout[i] = 16'd0;
      end
      test_reset();
      test_single_read();
      test_write();
      test_arbitration();
      test_timeout();
      test_ready();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
